// File: rtl/nr_div_pkg.sv
// rtl/nr_div_pkg.sv - shared constants, id type and state encoding for the division-core arbiter
package nr_div_pkg;

    localparam int DEF_N     = 4096;
    localparam int DEF_M     = 2048;
    localparam int DEF_BLOCK = 128;
    localparam int DEF_NREQ  = 4;

    // Beats per job at the default geometry
    localparam int IN_BEATS  = DEF_N / DEF_BLOCK;
    localparam int OUT_BEATS = (DEF_N - DEF_M) / DEF_BLOCK;

    typedef logic [$clog2(DEF_NREQ)-1:0] id_t;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set finder starting at ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW-1:0] idx;

    // Walk from the farthest slot back to ptr so the nearest set bit wins
    always_comb begin
        id  = '0;
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                id  = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nr_div_arbiter.sv
// rtl/nr_div_arbiter.sv - round-robin arbiter sharing one long-division core; optional watchdog via NR_DIV_ARB_TIMEOUT_EN
module nr_div_arbiter
    import nr_div_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int M       = DEF_M,
    parameter int BLOCK   = DEF_BLOCK,
    parameter int NREQ    = DEF_NREQ,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    input  logic [NREQ*BLOCK-1:0] din_dividend,
    input  logic [NREQ*BLOCK-1:0] din_divisor,
    input  logic [NREQ-1:0]       din_vld,
    output logic                  div_valid_in,
    output logic                  div_data_vld_in,
    output logic [BLOCK-1:0]      div_dividend,
    output logic [BLOCK-1:0]      div_divisor,
    input  logic [BLOCK-1:0]      div_quotient,
    input  logic                  div_data_vld_out,
    output logic [BLOCK-1:0]      rsp_quotient,
    output logic                  rsp_vld,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_done,
    output logic                  rsp_err
`ifdef NR_DIV_ARB_TIMEOUT_EN
    ,
    output logic                  div_abort
`endif
);

    localparam int IN_B  = N / BLOCK;
    localparam int OUT_B = (N - M) / BLOCK;
    localparam int ICW   = $clog2(IN_B) + 2;
    localparam int OCW   = $clog2(OUT_B) + 1;

    logic [2:0]       state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [ICW-1:0]   icnt_q, icnt_d;
    logic [OCW-1:0]   ocnt_q, ocnt_d;
    logic             err_q, err_d;
    logic [BLOCK-1:0] rsp_quotient_q, rsp_quotient_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_done_q, rsp_done_d;
    logic             rsp_err_q, rsp_err_d;
`ifdef NR_DIV_ARB_TIMEOUT_EN
    logic [15:0]      wd_q, wd_d;
    logic             div_abort_q, div_abort_d;
`endif

    logic [IDW-1:0]   pick_id;
    logic             pick_any;
    logic             own_vld;
    logic             active;
    logic             loading;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .id  (pick_id),
        .any (pick_any)
    );

    assign own_vld = din_vld[owner_q];
    assign active  = (state_q == S_GRANT) || (state_q == S_LOAD) ||
                     (state_q == S_WAIT)  || (state_q == S_DRAIN);
    assign loading = (state_q == S_LOAD);

    // Grant and load path are pure decodes of the owner so beats pass through with zero latency
    assign gnt             = active ? (NREQ'(1) << owner_q) : '0;
    assign div_valid_in    = (state_q == S_GRANT);
    assign div_data_vld_in = loading & own_vld;
    assign div_dividend    = loading ? din_dividend[int'(owner_q)*BLOCK +: BLOCK] : '0;
    assign div_divisor     = loading ? din_divisor[int'(owner_q)*BLOCK +: BLOCK]  : '0;

    assign rsp_quotient = rsp_quotient_q;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_done     = rsp_done_q;
    assign rsp_err      = rsp_err_q;
`ifdef NR_DIV_ARB_TIMEOUT_EN
    assign div_abort    = div_abort_q;
`endif

    // Job sequencing: pick, start core, count load beats, register quotient beats, release
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        ptr_d          = ptr_q;
        icnt_d         = icnt_q;
        ocnt_d         = ocnt_q;
        err_d          = err_q;
        rsp_quotient_d = rsp_quotient_q;
        rsp_id_d       = rsp_id_q;
        rsp_vld_d      = 1'b0;
        rsp_done_d     = 1'b0;
        rsp_err_d      = 1'b0;
`ifdef NR_DIV_ARB_TIMEOUT_EN
        wd_d           = wd_q;
        div_abort_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_id;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: state_d = S_LOAD;
            S_LOAD: begin
                if (own_vld) begin
                    // Extra beats are still forwarded but flag the job
                    if (icnt_q != {ICW{1'b1}}) icnt_d = icnt_q + 1'b1;
                    if (icnt_q >= ICW'(IN_B)) err_d = 1'b1;
                end else begin
                    if (icnt_q < ICW'(IN_B)) err_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT, S_DRAIN: begin
                if (div_data_vld_out) begin
                    rsp_quotient_d = div_quotient;
                    rsp_vld_d      = 1'b1;
                    rsp_id_d       = owner_q;
                    ocnt_d         = ocnt_q + 1'b1;
                    state_d        = S_DRAIN;
`ifdef NR_DIV_ARB_TIMEOUT_EN
                    wd_d           = '0;
`endif
                    if (ocnt_q == OCW'(OUT_B - 1)) begin
                        rsp_done_d = 1'b1;
                        rsp_err_d  = err_q;
                        state_d    = S_RELEASE;
                    end
                end
`ifdef NR_DIV_ARB_TIMEOUT_EN
                else if (wd_q == 16'(TIMEOUT - 1)) begin
                    rsp_done_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_id_d    = owner_q;
                    div_abort_d = 1'b1;
                    state_d     = S_RELEASE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            S_RELEASE: begin
                ptr_d   = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IDW'(1);
                icnt_d  = '0;
                ocnt_d  = '0;
                err_d   = 1'b0;
`ifdef NR_DIV_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            owner_q        <= '0;
            ptr_q          <= '0;
            icnt_q         <= '0;
            ocnt_q         <= '0;
            err_q          <= 1'b0;
            rsp_quotient_q <= '0;
            rsp_vld_q      <= 1'b0;
            rsp_id_q       <= '0;
            rsp_done_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
`ifdef NR_DIV_ARB_TIMEOUT_EN
            wd_q           <= '0;
            div_abort_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            ptr_q          <= ptr_d;
            icnt_q         <= icnt_d;
            ocnt_q         <= ocnt_d;
            err_q          <= err_d;
            rsp_quotient_q <= rsp_quotient_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_id_q       <= rsp_id_d;
            rsp_done_q     <= rsp_done_d;
            rsp_err_q      <= rsp_err_d;
`ifdef NR_DIV_ARB_TIMEOUT_EN
            wd_q           <= wd_d;
            div_abort_q    <= div_abort_d;
`endif
        end
    end

endmodule

// File: tb/tb_nr_div_arbiter.sv
// tb/tb_nr_div_arbiter.sv - randomized self-checking bench for nr_div_arbiter against a job-level reference model
module tb_nr_div_arbiter;
    import nr_div_pkg::*;

    localparam int NREQ  = 4;
    localparam int BLOCK = 128;
    localparam int TO    = 100;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ*BLOCK-1:0] din_dividend = '0;
    logic [NREQ*BLOCK-1:0] din_divisor = '0;
    logic [NREQ-1:0]       din_vld = '0;
    logic                  div_valid_in;
    logic                  div_data_vld_in;
    logic [BLOCK-1:0]      div_dividend;
    logic [BLOCK-1:0]      div_divisor;
    logic [BLOCK-1:0]      div_quotient = '0;
    logic                  div_data_vld_out = 1'b0;
    logic [BLOCK-1:0]      rsp_quotient;
    logic                  rsp_vld;
    logic [1:0]            rsp_id;
    logic                  rsp_done;
    logic                  rsp_err;
`ifdef NR_DIV_ARB_TIMEOUT_EN
    logic                  div_abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;

    always #5 clk = ~clk;

    nr_div_arbiter #(.TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .gnt              (gnt),
        .din_dividend     (din_dividend),
        .din_divisor      (din_divisor),
        .din_vld          (din_vld),
        .div_valid_in     (div_valid_in),
        .div_data_vld_in  (div_data_vld_in),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_quotient     (div_quotient),
        .div_data_vld_out (div_data_vld_out),
        .rsp_quotient     (rsp_quotient),
        .rsp_vld          (rsp_vld),
        .rsp_id           (rsp_id),
        .rsp_done         (rsp_done),
        .rsp_err          (rsp_err)
`ifdef NR_DIV_ARB_TIMEOUT_EN
        ,
        .div_abort        (div_abort)
`endif
    );

    task automatic check_eq(input string tag, input logic [BLOCK-1:0] got, input logic [BLOCK-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference arbitration: first pending requester at or after the pointer, wrapping
    function automatic int pick_exp(input logic [NREQ-1:0] r, input int p);
        int res = -1;
        for (int k = 0; k < NREQ; k++)
            if (res < 0 && r[(p + k) % NREQ]) res = (p + k) % NREQ;
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_din(input int own, input logic v, input logic [BLOCK-1:0] dvd, input logic [BLOCK-1:0] dvs);
        din_vld = NREQ'($urandom());
        din_vld[own] = v;
        for (int i = 0; i < NREQ; i++) begin
            din_dividend[i*BLOCK +: BLOCK] = rnd();
            din_divisor[i*BLOCK +: BLOCK]  = rnd();
        end
        din_dividend[own*BLOCK +: BLOCK] = dvd;
        din_divisor[own*BLOCK +: BLOCK]  = dvs;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_vld = NREQ'($urandom());
        step();
        step();
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_valid_in", div_valid_in, 0);
        check_eq("rst_data_vld_in", div_data_vld_in, 0);
        check_eq("rst_rsp_vld", rsp_vld, 0);
        check_eq("rst_rsp_done", rsp_done, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        ptr_m = 0;
    endtask

    // Waits for the grant, checks it against the model, then streams nbeats from the owner
    task automatic load_phase(input int nbeats, input bit idx_data, input int rst_at, output int own, output bit ok);
        int waited;
        logic [BLOCK-1:0] dvd, dvs;
        own = pick_exp(req, ptr_m);
        ok = 1'b0;
        waited = 0;
        step();
        while (gnt == '0 && waited < 10) begin
            step();
            waited++;
        end
        check_eq("gnt_seen", gnt != '0, 1);
        if (gnt == '0) return;
        check_eq("gnt_owner", gnt, 4'(1) << own);
        check_eq("start_pulse", div_valid_in, 1);
        for (int b = 0; b < nbeats; b++) begin
            step();
            if (b == rst_at) rst = 1'b1;
            dvd = idx_data ? BLOCK'(b) : rnd();
            dvs = idx_data ? BLOCK'(1) : rnd();
            drive_din(own, 1'b1, dvd, dvs);
            #1;
            check_eq("start_pulse_end", div_valid_in, 0);
            check_eq("fwd_vld", div_data_vld_in, 1);
            check_eq("fwd_dividend", div_dividend, dvd);
            check_eq("fwd_divisor", div_divisor, dvs);
            if (b == rst_at) begin
                step();
                check_eq("midrst_gnt", gnt, 0);
                check_eq("midrst_data_vld_in", div_data_vld_in, 0);
                check_eq("midrst_valid_in", div_valid_in, 0);
                check_eq("midrst_rsp_vld", rsp_vld, 0);
                rst = 1'b0;
                ptr_m = 0;
                drive_din(own, 1'b0, rnd(), rnd());
                return;
            end
        end
        step();
        drive_din(own, 1'b0, rnd(), rnd());
        #1;
        check_eq("fwd_stop", div_data_vld_in, 0);
        check_eq("gnt_load_hold", gnt, 4'(1) << own);
        ok = 1'b1;
    endtask

    task automatic run_job(input int nbeats, input bit idx_data, input bit rereq, input int rst_at);
        int own, k, cyc;
        bit ok, exp_v, exp_done, err_exp, stop;
        logic [BLOCK-1:0] exp_q;
        load_phase(nbeats, idx_data, rst_at, own, ok);
        if (!ok) return;
        err_exp = (nbeats != IN_BEATS);
        exp_v = 1'b0;
        exp_done = 1'b0;
        exp_q = '0;
        k = 0;
        cyc = 0;
        stop = 1'b0;
        while (!stop) begin
            step();
            cyc++;
            check_eq("rsp_vld", rsp_vld, exp_v);
            check_eq("rsp_done", rsp_done, exp_v & exp_done);
            check_eq("rsp_err", rsp_err, exp_v & exp_done & err_exp);
            if (exp_v) begin
                check_eq("rsp_quotient", rsp_quotient, exp_q);
                check_eq("rsp_id", rsp_id, own);
            end
            check_eq("gnt_job", gnt, (exp_v && exp_done) ? 0 : (4'(1) << own));
            if ((exp_v && exp_done) || cyc > 200) begin
                stop = 1'b1;
            end else if (k < OUT_BEATS && $urandom_range(0, 3) != 0) begin
                div_data_vld_out = 1'b1;
                div_quotient = rnd();
                exp_q = div_quotient;
                exp_v = 1'b1;
                exp_done = (k == OUT_BEATS - 1);
                k++;
            end else begin
                div_data_vld_out = 1'b0;
                exp_v = 1'b0;
                exp_done = 1'b0;
            end
        end
        check_eq("drain_in_budget", cyc <= 200, 1);
        div_data_vld_out = 1'b0;
        ptr_m = (own + 1) % NREQ;
        if (!rereq) req[own] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nb, r;
        do_reset();

        // Single requester with indexed dividends and unit divisor
        req = 4'b0001;
        run_job(IN_BEATS, 1'b1, 1'b0, -1);

        // Everyone requesting from a fresh pointer: expect 0,1,2,3
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < NREQ; j++) run_job(IN_BEATS, 1'b0, 1'b0, -1);

        // Pointer fairness: after serving id 1, id 0 outranks a re-request of id 1
        req = 4'b0010;
        run_job(IN_BEATS, 1'b0, 1'b0, -1);
        req = 4'b0011;
        run_job(IN_BEATS, 1'b0, 1'b0, -1);
        run_job(IN_BEATS, 1'b0, 1'b0, -1);

        // Short load then a gap
        req = 4'b0100;
        run_job(20, 1'b0, 1'b0, -1);

        // Reset during load returns the pointer to 0
        req = 4'b1000;
        run_job(IN_BEATS, 1'b0, 1'b0, 10);
        req = 4'b1111;
        run_job(IN_BEATS, 1'b0, 1'b0, -1);

`ifdef NR_DIV_ARB_TIMEOUT_EN
        begin : timeout_case
            int own;
            bit ok;
            req = req | 4'b0100;
            load_phase(IN_BEATS, 1'b0, -1, own, ok);
            if (ok) begin
                for (int w = 0; w <= TO; w++) begin
                    step();
                    check_eq("to_done", rsp_done, w == TO);
                    check_eq("to_err", rsp_err, w == TO);
                    check_eq("to_abort", div_abort, w == TO);
                end
                check_eq("to_id", rsp_id, own);
            end
            ptr_m = (own + 1) % NREQ;
            req[own] = 1'b0;
            req = req | 4'b0001;
            run_job(IN_BEATS, 1'b0, 1'b0, -1);
        end
`endif

        // Random traffic: new requests, re-requests, short and long loads
        for (int j = 0; j < 12; j++) begin
            req = req | NREQ'($urandom());
            if (req == '0) req[0] = 1'b1;
            r = $urandom_range(0, 9);
            nb = (r < 7) ? IN_BEATS : (r < 8) ? $urandom_range(1, IN_BEATS - 1) : $urandom_range(IN_BEATS + 1, IN_BEATS + 3);
            run_job(nb, 1'b0, $urandom_range(0, 3) == 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nr_div_arbiter.md
Name: nr_div_arbiter

Overview:
- Round-robin scheduler that shares one restoring/non-restoring long-division core among NREQ requesters in the L-function path.
- Grants one requester at a time and starts the core.
- Forwards that requester's BLOCK-wide dividend/divisor stream to the core, then routes the returned quotient beats back tagged with the requester id.
- Releases the core after the last quotient beat, then advances the priority pointer.

Parameters:
- N, 4096, dividend width in bits.
- M, 2048, divisor width in bits.
- BLOCK, 128, beat width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, id width, equal to clog2(NREQ).
- TIMEOUT, 65535, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request level; held until rsp_done
- gnt  out  NREQ  one-hot grant; held from GRANT through DRAIN
- din_dividend  in  NREQ*BLOCK  per-requester dividend beat; slice i = [i*BLOCK +: BLOCK]
- din_divisor  in  NREQ*BLOCK  per-requester divisor beat; same slicing
- din_vld  in  NREQ  per-requester beat valid
- div_valid_in  out  1  start pulse to the core
- div_data_vld_in  out  1  beat valid to the core
- div_dividend  out  BLOCK  muxed dividend beat
- div_divisor  out  BLOCK  muxed divisor beat
- div_quotient  in  BLOCK  quotient beat from the core
- div_data_vld_out  in  1  quotient beat valid from the core
- rsp_quotient  out  BLOCK  registered quotient beat
- rsp_vld  out  1  quotient beat valid
- rsp_id  out  IDW  owner of the current response
- rsp_done  out  1  one-cycle pulse with the final beat
- rsp_err  out  1  one-cycle pulse, coincident with rsp_done or the timeout abort

Behaviour:
- Constants:
  - IN_BEATS = N/BLOCK (32).
  - OUT_BEATS = (N-M)/BLOCK (16).
- Reset values: all outputs 0; state IDLE; priority pointer ptr = 0; counters 0; err flag 0.
- IDLE:
  - If req != 0, pick the first set bit searching ptr, ptr+1, … mod NREQ.
  - Register owner id; go to GRANT.
- GRANT (1 cycle):
  - gnt[owner] = 1 and div_valid_in = 1.
  - Next state LOAD.
- LOAD:
  - div_data_vld_in, div_dividend and div_divisor are combinational muxes of din_*[owner]; zero-latency pass-through.
  - The owner drives its first beat in the cycle after gnt first rises; beats must be contiguous.
  - Count forwarded beats.
  - When count reaches IN_BEATS and din_vld[owner] = 0, go to WAIT.
  - Gap (din_vld low while count < IN_BEATS): set sticky err; go to WAIT.
  - Beats beyond IN_BEATS: set err; still forwarded.
  - din_vld from non-owners is ignored in every state.
- WAIT / DRAIN:
  - Each div_data_vld_out beat is registered into rsp_quotient with rsp_vld = 1 and rsp_id = owner, one cycle later.
  - Count the beats; state moves to DRAIN on the first beat.
  - On beat OUT_BEATS: rsp_done = 1, and rsp_err = err on that same beat. Go to RELEASE.
- RELEASE (1 cycle):
  - gnt = 0; ptr = owner+1 mod NREQ; clear counters and err; go to IDLE.
  - Minimum idle gap between grants: 1 cycle.
- Simultaneous events:
  - New requests during a job are ignored until IDLE.
  - req[owner] dropping mid-job does not abort the job.
  - The owner may re-request; it is granted only after the other pending requesters at or after ptr.
- rst mid-operation: immediate return to IDLE with all outputs 0. Resetting the core is the integrator's duty (shared rst).

Optional Feature:
- Macro NR_DIV_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit watchdog counts cycles spent in WAIT/DRAIN without div_data_vld_out.
  - On reaching TIMEOUT: pulse rsp_err with rsp_done = 1 and rsp_id = owner, pulse extra output div_abort for 1 cycle, go to RELEASE.
- Without the macro: no watchdog, no div_abort port; the arbiter waits indefinitely.

Decomposition:
- Package nr_div_pkg holds IN_BEATS, OUT_BEATS, the state encoding (IDLE, GRANT, LOAD, WAIT, DRAIN, RELEASE) and the id typedef.
- One sub-module, rr_pick: combinational round-robin first-set finder (req, ptr -> id, any).

Test Plan:
- Single requester:
  - Stimulus: req = 0001; 32 contiguous beats, dividend = beat index, divisor = 0x1 in the low beats.
  - Response: gnt = 0001 and div_valid_in pulse in the same cycle; 32 forwarded beats; 16 rsp_vld beats with rsp_id = 0; rsp_done on the 16th beat; rsp_err = 0.
- All requesters:
  - Stimulus: req = 1111 after reset.
  - Response: grant order 0, 1, 2, 3; each job complete before the next gnt; rsp_id matches each job.
- Pointer fairness:
  - Stimulus: ptr = 2 after serving id 1; req = 0011.
  - Response: id 0 is granted before id 1.
- Short load:
  - Stimulus: 20 beats, then a gap.
  - Response: state goes to WAIT; rsp_err = 1 with rsp_done.
- Reset in LOAD:
  - Stimulus: assert rst at beat 10.
  - Response: next cycle gnt = 0, div_data_vld_in = 0, ptr = 0.
- Timeout (with NR_DIV_ARB_TIMEOUT_EN, TIMEOUT = 100):
  - Stimulus: the core never returns beats.
  - Response: rsp_err and rsp_done pulse 100 cycles after entering WAIT; div_abort pulses; the next requester is granted.
